// File: rtl/rr_bus_pkg.sv
// Shared definitions for the 2-master / 2-slave round-robin bus:
// request-state encoding and command values used by masters and ack arbiters.
package rr_bus_pkg;

  localparam int unsigned REQ_STAT_W = 2;

  typedef enum logic [REQ_STAT_W-1:0] {
    NO_REQ = 2'd0,
    WAIT   = 2'd1,
    W_ACK  = 2'd2,
    W_DATA = 2'd3
  } req_stat_t;

  localparam logic CMD_READ  = 1'b0;
  localparam logic CMD_WRITE = 1'b1;

  // States in which the master is waiting on the bus and may time out.
  function automatic logic is_timed_state(input req_stat_t s);
    return (s == W_ACK) || (s == W_DATA);
  endfunction

endpackage

// File: rtl/req_timeout_cnt.sv
// Cycle counter for W_ACK / W_DATA; expired is high in the cycle whose closing
// edge would bring the count to TO_CYC. TO_CYC = 0 disables expiry.
module req_timeout_cnt #(
  parameter int unsigned TO_CYC = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int unsigned CW = (TO_CYC == 0) ? 1 : $clog2(TO_CYC + 1);
  localparam bit TO_ON = (TO_CYC != 0);
  localparam logic [CW-1:0] LIMIT = TO_ON ? CW'(TO_CYC - 1) : '0;

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign expired = TO_ON && en && (cnt == LIMIT);

endmodule

// File: rtl/mas_req_fsm.sv
// Master-side request controller: captures one transaction, publishes
// sfor/req_stat to the ack arbiters and returns ack/resp/err pulses to the master.
module mas_req_fsm
  import rr_bus_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned TO_CYC = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              master_req,
  input  logic              master_cmd,
  input  logic [ADDR_W-1:0] master_addr,
  input  logic [DATA_W-1:0] master_wdata,
  output logic              master_busy,
  output logic              master_ack,
  output logic              master_resp,
  output logic [DATA_W-1:0] master_rdata,
  output logic              master_err,
  output logic              sfor,
  output req_stat_t         req_stat,
  output logic [ADDR_W-1:0] bus_addr,
  output logic              bus_cmd,
  output logic [DATA_W-1:0] bus_wdata,
  input  logic              ack_in,
  input  logic              resp_in,
  input  logic [DATA_W-1:0] rdata_in
);

  req_stat_t state_d;
  logic      capture_c;
  logic      rdata_cap_c;
  logic      ack_d;
  logic      resp_d;
  logic      err_d;
  logic      to_clr_c;
  logic      to_en_c;
  logic      expired_c;

  // Counter restarts on every entry into a timed state.
  assign to_en_c  = is_timed_state(req_stat);
  assign to_clr_c = !to_en_c || (state_d != req_stat);

  req_timeout_cnt #(
    .TO_CYC (TO_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clr     (to_clr_c),
    .en      (to_en_c),
    .expired (expired_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      req_stat <= NO_REQ;
    end else begin
      req_stat <= state_d;
    end
  end

  // Next state and pulse decisions; an ack/resp event beats a same-cycle expiry.
  always_comb begin
    state_d     = req_stat;
    capture_c   = 1'b0;
    rdata_cap_c = 1'b0;
    ack_d       = 1'b0;
    resp_d      = 1'b0;
    err_d       = 1'b0;
    unique case (req_stat)
      NO_REQ: begin
        if (master_req) begin
          capture_c = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: begin
        state_d = W_ACK;
      end
      W_ACK: begin
        if (ack_in) begin
          ack_d   = 1'b1;
          state_d = (bus_cmd == CMD_WRITE) ? NO_REQ : W_DATA;
        end else if (expired_c) begin
          err_d   = 1'b1;
          state_d = NO_REQ;
        end
      end
      W_DATA: begin
        if (resp_in) begin
          resp_d      = 1'b1;
          rdata_cap_c = 1'b1;
          state_d     = NO_REQ;
        end else if (expired_c) begin
          err_d   = 1'b1;
          state_d = NO_REQ;
        end
      end
      default: state_d = NO_REQ;
    endcase
  end

  // Registered outputs toward the master and the slave side.
  always_ff @(posedge clk) begin
    if (rst) begin
      master_busy  <= 1'b0;
      master_ack   <= 1'b0;
      master_resp  <= 1'b0;
      master_err   <= 1'b0;
      master_rdata <= '0;
      sfor         <= 1'b0;
      bus_addr     <= '0;
      bus_cmd      <= 1'b0;
      bus_wdata    <= '0;
    end else begin
      master_busy <= (state_d != NO_REQ);
      master_ack  <= ack_d;
      master_resp <= resp_d;
      master_err  <= err_d;
      if (rdata_cap_c) begin
        master_rdata <= rdata_in;
      end
      if (capture_c) begin
        sfor      <= master_addr[ADDR_W-1];
        bus_addr  <= master_addr;
        bus_cmd   <= master_cmd;
        bus_wdata <= master_wdata;
      end
    end
  end

endmodule

// File: tb/tb_mas_req_fsm.sv
// Directed bench for mas_req_fsm with TO_CYC = 4: write, read, timeout,
// busy/stray inputs, reset mid-transaction and back-to-back requests.
module tb_mas_req_fsm;
  import rr_bus_pkg::*;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned TO_CYC = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              master_req;
  logic              master_cmd;
  logic [ADDR_W-1:0] master_addr;
  logic [DATA_W-1:0] master_wdata;
  logic              master_busy;
  logic              master_ack;
  logic              master_resp;
  logic [DATA_W-1:0] master_rdata;
  logic              master_err;
  logic              sfor;
  req_stat_t         req_stat;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_cmd;
  logic [DATA_W-1:0] bus_wdata;
  logic              ack_in;
  logic              resp_in;
  logic [DATA_W-1:0] rdata_in;

  int n_chk  = 0;
  int n_fail = 0;

  mas_req_fsm #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W),
    .TO_CYC (TO_CYC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .master_req   (master_req),
    .master_cmd   (master_cmd),
    .master_addr  (master_addr),
    .master_wdata (master_wdata),
    .master_busy  (master_busy),
    .master_ack   (master_ack),
    .master_resp  (master_resp),
    .master_rdata (master_rdata),
    .master_err   (master_err),
    .sfor         (sfor),
    .req_stat     (req_stat),
    .bus_addr     (bus_addr),
    .bus_cmd      (bus_cmd),
    .bus_wdata    (bus_wdata),
    .ack_in       (ack_in),
    .resp_in      (resp_in),
    .rdata_in     (rdata_in)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_pulses(input string tag, input logic a, input logic r, input logic e);
    chk({tag, "_ack"},  64'(master_ack),  64'(a));
    chk({tag, "_resp"}, 64'(master_resp), 64'(r));
    chk({tag, "_err"},  64'(master_err),  64'(e));
  endtask

  task automatic issue(input logic cmd, input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] wd);
    master_req   = 1'b1;
    master_cmd   = cmd;
    master_addr  = addr;
    master_wdata = wd;
  endtask

  initial begin
    rst = 1'b1; master_req = 1'b0; master_cmd = 1'b0; master_addr = '0;
    master_wdata = '0; ack_in = 1'b0; resp_in = 1'b0; rdata_in = '0;
    tick(); tick();
    rst = 1'b0;
    chk("rst_state", 64'(req_stat), 64'(0));
    chk("rst_busy",  64'(master_busy), 64'(0));
    chk("rst_sfor",  64'(sfor), 64'(0));
    chk("rst_baddr", 64'(bus_addr), 64'(0));
    chk("rst_rdata", 64'(master_rdata), 64'(0));
    chk_pulses("rst", 1'b0, 1'b0, 1'b0);

    // Write to slave 1, ack sampled at E3
    issue(1'b1, 32'h8000_0010, 32'hA5A5_A5A5);
    tick();
    master_req = 1'b0;
    chk("wr_e0_state", 64'(req_stat), 64'(1));
    chk("wr_e0_sfor",  64'(sfor), 64'(1));
    chk("wr_e0_busy",  64'(master_busy), 64'(1));
    chk("wr_e0_addr",  64'(bus_addr), 64'h8000_0010);
    chk("wr_e0_wdata", 64'(bus_wdata), 64'hA5A5_A5A5);
    chk("wr_e0_cmd",   64'(bus_cmd), 64'(1));
    tick();
    chk("wr_e1_state", 64'(req_stat), 64'(2));
    tick();
    chk("wr_e2_state", 64'(req_stat), 64'(2));
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    chk("wr_e3_state", 64'(req_stat), 64'(0));
    chk("wr_e3_busy",  64'(master_busy), 64'(0));
    chk_pulses("wr_e3", 1'b1, 1'b0, 1'b0);
    tick();
    chk_pulses("wr_e4", 1'b0, 1'b0, 1'b0);

    // Read from slave 0, data returned two cycles after ack
    issue(1'b0, 32'h0000_0004, 32'h0);
    tick();
    master_req = 1'b0;
    chk("rd_e0_sfor", 64'(sfor), 64'(0));
    tick();
    chk("rd_e1_state", 64'(req_stat), 64'(2));
    tick();
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    chk("rd_e3_state", 64'(req_stat), 64'(3));
    chk_pulses("rd_e3", 1'b1, 1'b0, 1'b0);
    tick();
    chk("rd_e4_state", 64'(req_stat), 64'(3));
    chk_pulses("rd_e4", 1'b0, 1'b0, 1'b0);
    resp_in = 1'b1; rdata_in = 32'h1234_5678;
    tick();
    resp_in = 1'b0; rdata_in = 32'hFFFF_FFFF;
    chk("rd_resp_state", 64'(req_stat), 64'(0));
    chk("rd_resp_rdata", 64'(master_rdata), 64'h1234_5678);
    chk_pulses("rd_resp", 1'b0, 1'b1, 1'b0);
    tick();
    chk("rd_hold_rdata", 64'(master_rdata), 64'h1234_5678);
    chk_pulses("rd_hold", 1'b0, 1'b0, 1'b0);

    // Timeout in W_ACK: err 4 cycles after entering W_ACK
    issue(1'b1, 32'h0000_0020, 32'h1);
    tick();
    master_req = 1'b0;
    tick();
    chk("to_entry_state", 64'(req_stat), 64'(2));
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk($sformatf("to_wait%0d_state", i), 64'(req_stat), 64'(2));
      chk($sformatf("to_wait%0d_err", i), 64'(master_err), 64'(0));
    end
    tick();
    chk("to_exp_state", 64'(req_stat), 64'(0));
    chk_pulses("to_exp", 1'b0, 1'b0, 1'b1);
    tick();
    chk_pulses("to_after", 1'b0, 1'b0, 1'b0);

    // Ack on the expiry cycle: ack wins
    issue(1'b1, 32'h0000_0030, 32'h2);
    tick();
    master_req = 1'b0;
    tick(); tick(); tick(); tick();
    chk("race_pre_state", 64'(req_stat), 64'(2));
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    chk("race_state", 64'(req_stat), 64'(0));
    chk_pulses("race", 1'b1, 1'b0, 1'b0);

    // Busy: new request and stray resp_in during W_ACK are ignored
    issue(1'b1, 32'h8000_0100, 32'h0000_0001);
    tick();
    tick();
    issue(1'b1, 32'h0000_0FFF, 32'hDEAD_BEEF);
    resp_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk($sformatf("busy%0d_addr", i), 64'(bus_addr), 64'h8000_0100);
      chk($sformatf("busy%0d_wdata", i), 64'(bus_wdata), 64'h1);
      chk($sformatf("busy%0d_resp", i), 64'(master_resp), 64'(0));
    end
    master_req = 1'b0; resp_in = 1'b0; ack_in = 1'b1;
    tick();
    chk("busy_ack", 64'(master_ack), 64'(1));
    chk("busy_state", 64'(req_stat), 64'(0));
    // ack_in stays high in NO_REQ: no further pulses
    tick();
    chk_pulses("stray_ack0", 1'b0, 1'b0, 1'b0);
    tick();
    ack_in = 1'b0;
    chk_pulses("stray_ack1", 1'b0, 1'b0, 1'b0);
    chk("stray_state", 64'(req_stat), 64'(0));

    // Reset while in W_DATA
    issue(1'b0, 32'h8000_0000, 32'h0);
    tick();
    master_req = 1'b0;
    tick(); tick();
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    chk("mrst_pre_state", 64'(req_stat), 64'(3));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mrst_state", 64'(req_stat), 64'(0));
    chk("mrst_busy",  64'(master_busy), 64'(0));
    chk("mrst_sfor",  64'(sfor), 64'(0));
    chk("mrst_addr",  64'(bus_addr), 64'(0));
    chk("mrst_rdata", 64'(master_rdata), 64'(0));
    chk_pulses("mrst", 1'b0, 1'b0, 1'b0);
    resp_in = 1'b1; rdata_in = 32'hCAFE_F00D;
    tick();
    resp_in = 1'b0;
    chk("mrst_stray_rdata", 64'(master_rdata), 64'(0));
    chk_pulses("mrst_stray", 1'b0, 1'b0, 1'b0);

    // Back-to-back writes: slave 0 then slave 1, req held high throughout
    issue(1'b1, 32'h0000_0010, 32'h11);
    tick();
    chk("b2b_a_sfor", 64'(sfor), 64'(0));
    issue(1'b1, 32'h8000_0020, 32'h22);
    tick();
    chk("b2b_e1_sfor", 64'(sfor), 64'(0));
    tick();
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    chk("b2b_e3_state", 64'(req_stat), 64'(0));
    chk("b2b_e3_sfor",  64'(sfor), 64'(0));
    chk("b2b_e3_addr",  64'(bus_addr), 64'h0000_0010);
    chk("b2b_e3_ack",   64'(master_ack), 64'(1));
    tick();
    master_req = 1'b0;
    chk("b2b_b_state", 64'(req_stat), 64'(1));
    chk("b2b_b_sfor",  64'(sfor), 64'(1));
    chk("b2b_b_addr",  64'(bus_addr), 64'h8000_0020);
    chk("b2b_b_wdata", 64'(bus_wdata), 64'h22);
    tick(); tick();
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    chk("b2b_b_done", 64'(req_stat), 64'(0));
    chk_pulses("b2b_b", 1'b1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
